// File: rtl/nco_core.sv
// Numerically controlled oscillator: phase accumulator feeding a 16-stage
// pipelined CORDIC that produces quadrature sine/cosine samples.
module nco_core #(
  parameter int ACC_W = 32,
  parameter int PH_W  = 16,
  parameter int OUT_W = 14
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             clken,
  input  logic [ACC_W-1:0] phi_inc_i,
  input  logic [ACC_W-1:0] freq_mod_i,
  input  logic [PH_W-1:0]  phase_mod_i,
  output logic [OUT_W-1:0] fsin_o,
  output logic [OUT_W-1:0] fcos_o,
  output logic             out_valid
);

  localparam int NST = 16;
  localparam int LAT = NST + 2;
  localparam int GB  = 4;
  localparam int XW  = OUT_W + GB + 2;
  localparam int ZW  = 26;
  localparam int ZSH = 24 - PH_W;
  localparam int AMP = 2 ** (OUT_W - 1) - 1;
  // Start vector pre-scaled by the inverse CORDIC gain so the result lands on AMP.
  localparam int X0  = $rtoi(real'(AMP) * real'(2 ** GB) * 0.6072529350088813 + 0.5);

  localparam logic signed [XW-1:0] POS_LIM = XW'(AMP);
  localparam logic signed [XW-1:0] NEG_LIM = XW'(-AMP);
  localparam logic signed [XW-1:0] RND     = XW'(2 ** (GB - 1));

  // atan(2^-i) with a full circle equal to 2^24
  function automatic logic signed [ZW-1:0] atan_lut(input int i);
    logic signed [ZW-1:0] r;
    case (i)
      0:       r = ZW'(2097152);
      1:       r = ZW'(1238021);
      2:       r = ZW'(654136);
      3:       r = ZW'(332050);
      4:       r = ZW'(166669);
      5:       r = ZW'(83416);
      6:       r = ZW'(41718);
      7:       r = ZW'(20860);
      8:       r = ZW'(10430);
      9:       r = ZW'(5215);
      10:      r = ZW'(2608);
      11:      r = ZW'(1304);
      12:      r = ZW'(652);
      13:      r = ZW'(326);
      14:      r = ZW'(163);
      15:      r = ZW'(81);
      default: r = '0;
    endcase
    return r;
  endfunction

  function automatic logic [OUT_W-1:0] round_sat(input logic signed [XW-1:0] v,
                                                 input logic flip);
    logic signed [XW-1:0] f;
    logic signed [XW-1:0] r;
    f = flip ? -v : v;
    r = (f + RND) >>> GB;
    if (r > POS_LIM)
      return POS_LIM[OUT_W-1:0];
    else if (r < NEG_LIM)
      return NEG_LIM[OUT_W-1:0];
    else
      return r[OUT_W-1:0];
  endfunction

  logic [ACC_W-1:0]     acc_reg;
  logic [PH_W-1:0]      theta;
  logic [PH_W-1:0]      theta_fold;
  logic                 quad_neg;
  logic signed [ZW-1:0] z_first;
  logic signed [XW-1:0] x_reg [0:NST];
  logic signed [XW-1:0] y_reg [0:NST];
  logic signed [ZW-1:0] z_reg [0:NST];
  logic [NST:0]         neg_reg;
  logic [LAT-1:0]       valid_reg;
  logic [OUT_W-1:0]     sin_next;
  logic [OUT_W-1:0]     cos_next;

  // Angles outside +/-pi/2 are rotated by pi; the result is negated at the end.
  always_comb begin
    theta      = acc_reg[ACC_W-1 -: PH_W] + phase_mod_i;
    quad_neg   = theta[PH_W-1] ^ theta[PH_W-2];
    theta_fold = theta ^ {quad_neg, {(PH_W-1){1'b0}}};
    z_first    = {{(ZW-PH_W){theta_fold[PH_W-1]}}, theta_fold} << ZSH;
    sin_next   = round_sat(y_reg[NST], neg_reg[NST]);
    cos_next   = round_sat(x_reg[NST], neg_reg[NST]);
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      acc_reg <= '0;
      for (int i = 0; i <= NST; i++) begin
        x_reg[i] <= '0;
        y_reg[i] <= '0;
        z_reg[i] <= '0;
      end
      neg_reg   <= '0;
      valid_reg <= '0;
      fsin_o    <= '0;
      fcos_o    <= '0;
    end else if (clken) begin
      acc_reg    <= acc_reg + phi_inc_i + freq_mod_i;
      x_reg[0]   <= XW'(X0);
      y_reg[0]   <= '0;
      z_reg[0]   <= z_first;
      neg_reg[0] <= quad_neg;
      for (int i = 0; i < NST; i++) begin
        if (z_reg[i][ZW-1]) begin
          x_reg[i+1] <= x_reg[i] + (y_reg[i] >>> i);
          y_reg[i+1] <= y_reg[i] - (x_reg[i] >>> i);
          z_reg[i+1] <= z_reg[i] + atan_lut(i);
        end else begin
          x_reg[i+1] <= x_reg[i] - (y_reg[i] >>> i);
          y_reg[i+1] <= y_reg[i] + (x_reg[i] >>> i);
          z_reg[i+1] <= z_reg[i] - atan_lut(i);
        end
        neg_reg[i+1] <= neg_reg[i];
      end
      fsin_o    <= sin_next;
      fcos_o    <= cos_next;
      valid_reg <= {valid_reg[LAT-2:0], 1'b1};
    end
  end

  assign out_valid = valid_reg[LAT-1];

endmodule

// File: tb/tb_nco_core.sv
// Randomised scoreboard bench for nco_core: expected phases are queued per
// enabled cycle and compared against real-valued sin/cos when samples emerge.
module tb_nco_core;

  localparam real PI  = 3.14159265358979;
  localparam int  LAT = 18;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        clken;
  logic [31:0] phi_inc;
  logic [31:0] freq_mod;
  logic [15:0] phase_mod;
  logic [13:0] fsin;
  logic [13:0] fcos;
  logic        out_valid;

  nco_core dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .clken      (clken),
    .phi_inc_i  (phi_inc),
    .freq_mod_i (freq_mod),
    .phase_mod_i(phase_mod),
    .fsin_o     (fsin),
    .fcos_o     (fcos),
    .out_valid  (out_valid)
  );

  always #5 clk = ~clk;

  int        theta_q[$];
  bit [31:0] acc_m;
  int        cnt_m;
  bit        edge_rst;
  bit        edge_en;
  bit        started = 1'b0;
  int        last_th = 0;
  int        pass_cnt = 0;
  int        tot_cnt = 0;

  function automatic int ref_sin(int th);
    return int'($floor(8191.0 * $sin(2.0 * PI * real'(th) / 65536.0) + 0.5));
  endfunction

  function automatic int ref_cos(int th);
    return int'($floor(8191.0 * $cos(2.0 * PI * real'(th) / 65536.0) + 0.5));
  endfunction

  function automatic int sx(logic [13:0] v);
    return int'($signed(v));
  endfunction

  task automatic chk(string name, int act, int exp, int tol);
    int d;
    tot_cnt++;
    d = act - exp;
    if (d < 0) d = -d;
    if (d <= tol)
      pass_cnt++;
    else
      $display("FAIL %s act=%0d exp=%0d tol=%0d t=%0t", name, act, exp, tol, $time);
  endtask

  // Book the upcoming edge in the reference model, then let it happen.
  task automatic step(int n);
    repeat (n) begin
      edge_rst = !reset_n;
      edge_en  = clken;
      if (!reset_n) begin
        theta_q.delete();
        acc_m = '0;
        cnt_m = 0;
      end else if (clken) begin
        theta_q.push_back(int'(((acc_m >> 16) + 32'(phase_mod)) % 65536));
        acc_m = acc_m + phi_inc + freq_mod;
        if (cnt_m < LAT) cnt_m++;
      end
      started = 1'b1;
      @(posedge clk);
      @(negedge clk);
    end
  endtask

  always @(posedge clk) begin
    #1;
    if (started) begin
      if (edge_rst) begin
        chk("rst_valid", int'(out_valid), 0, 0);
        chk("rst_sin", sx(fsin), 0, 0);
        chk("rst_cos", sx(fcos), 0, 0);
      end else begin
        chk("valid", int'(out_valid), int'(cnt_m >= LAT), 0);
        if (cnt_m >= LAT) begin
          if (edge_en) begin
            if (theta_q.size() == 0)
              chk("queue_underflow", 0, 1, 0);
            else
              last_th = theta_q.pop_front();
          end
          chk("sin", sx(fsin), ref_sin(last_th), 2);
          chk("cos", sx(fcos), ref_cos(last_th), 2);
          chk("sin_floor", int'(sx(fsin) >= -8191), 1, 0);
          chk("cos_floor", int'(sx(fcos) >= -8191), 1, 0);
        end
      end
    end
  end

  initial begin
    reset_n   = 1'b0;
    clken     = 1'b1;
    phi_inc   = '0;
    freq_mod  = '0;
    phase_mod = '0;
    step(3);
    reset_n = 1'b1;
    step(25);

    phase_mod = 16'd16384; step(20);
    phase_mod = 16'd32768; step(20);
    phase_mod = 16'd49152; step(20);

    reset_n   = 1'b0;
    phi_inc   = 32'h051E_B852;
    freq_mod  = 32'h1000_0000;
    phase_mod = 16'd4096;
    step(7);
    reset_n = 1'b1;
    step(40);

    reset_n = 1'b0;
    step(2);
    reset_n   = 1'b1;
    phi_inc   = 32'h4000_0000;
    freq_mod  = '0;
    phase_mod = '0;
    step(30);

    clken = 1'b0; step(5);
    clken = 1'b1; step(10);

    reset_n = 1'b0; step(1);
    reset_n = 1'b1; step(25);

    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 15) == 0) begin
        phi_inc   = $urandom;
        freq_mod  = $urandom;
        phase_mod = 16'($urandom);
      end
      clken   = ($urandom_range(0, 4) != 0);
      reset_n = ($urandom_range(0, 299) != 0);
      step(1);
    end
    clken   = 1'b1;
    reset_n = 1'b1;
    step(25);

    $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
    $finish;
  end

endmodule
